// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, round functions and FSM state type.
// Imported by the compression core and the message scheduler.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_e;

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/ep1.sv
// EP1 block: SHA-256 Sigma1 of the working register e.
// Pure combinational rotate/xor network.
module ep1 (
    input  logic [31:0] x,
    output logic [31:0] y
);

    assign y = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule as a 16-word sliding window.
// W[0] is the word consumed by the current round.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [511:0] block_in,
    input  logic         en,
    output logic [31:0]  w0
);

    word_t w_q [16];
    word_t w_d [16];

    // Load a fresh block or shift the window and append the next expanded word.
    always_comb begin
        for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
        if (load) begin
            for (int i = 0; i < 16; i++) w_d[i] = block_in[511-32*i -: 32];
        end else if (en) begin
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        end
    end

    // Window storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
        end
    end

    assign w0 = w_q[0];

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression, one round per clock.
// Chaining value is kept between blocks for multi-block messages.
module sha256_compress_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         first_block,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out
);

    state_e       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [255:0] digest_q, digest_d;
    word_t        h_q [8];
    word_t        h_d [8];
    word_t        wv_q [8];
    word_t        wv_d [8];

    logic  sched_load;
    logic  sched_en;
    word_t w0;
    word_t ep1_e;
    word_t t1;
    word_t t2;

    ep1 u_ep1 (
        .x (wv_q[4]),
        .y (ep1_e)
    );

    sha256_msg_sched u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sched_load),
        .block_in (block_in),
        .en       (sched_en),
        .w0       (w0)
    );

    // Next-state, round datapath and chaining-value update.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        digest_d    = digest_q;
        for (int i = 0; i < 8; i++) begin
            h_d[i]  = h_q[i];
            wv_d[i] = wv_q[i];
        end
        sched_load = 1'b0;
        sched_en   = 1'b0;
        t1 = wv_q[7] + ep1_e + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q] + w0;
        t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < 8; i++) begin
                        if (first_block) h_d[i] = IV[i];
                        wv_d[i] = first_block ? IV[i] : h_q[i];
                    end
                    sched_load = 1'b1;
                    t_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                sched_en = 1'b1;
                for (int i = 1; i < 8; i++) wv_d[i] = wv_q[i-1];
                wv_d[4] = wv_q[3] + t1;
                wv_d[0] = t1 + t2;
                t_d     = t_q + 6'd1;
                if (t_q == 6'(ROUNDS - 1)) state_d = FINAL;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                    digest_d[255-32*i -: 32] = h_q[i] + wv_q[i];
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, working variables and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            digest_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= '0;
                wv_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            digest_q    <= digest_d;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= h_d[i];
                wv_q[i] <= wv_d[i];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign digest_out = digest_q;

endmodule
